fib_tmr_buf_sched: RTL
======================

Name: fib_tmr_buf_sched

Overview:
- Schedules the two data producers (Fibonacci, Timer) into one shared FIFO and paces the consumer that feeds the display path.
- Owns the 6-state communication FSM, the FIFO storage and occupancy, the producer handshakes and the consumer pop timing.
- Sits between the edge-detected button pulses / producer modules and the display formatter.

Parameters:
- DATA_W, 16, producer/consumer data width
- DEPTH, 8, FIFO entries (power of two, >=4)
- LOW_WM, 4, occupancy at or below which a WAIT state resumes production

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- start_f  in  1  one-cycle pulse (already edge-detected): start/continue Fibonacci
- start_t  in  1  one-cycle pulse: start/continue Timer
- stop_f_t  in  1  one-cycle pulse: stop production, drain buffer
- f_valid  in  1  Fibonacci word available
- f_data  in  DATA_W  Fibonacci word
- f_ack  out  1  Fibonacci word accepted this cycle; producer advances only on f_ack
- t_valid  in  1  Timer word available
- t_data  in  DATA_W  Timer word
- t_ack  out  1  Timer word accepted this cycle
- cons_tick  in  1  slow-clock enable pulse; requests one pop
- data_2  out  DATA_W  popped word
- data_2_valid  out  1  data_2 valid, one-cycle pulse
- buffer_full  out  1  count == DEPTH
- buffer_empty  out  1  count == 0
- led  out  6  one-hot state indicator (bit0 IDLE … bit5 BUF_EMPTY)

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - state=IDLE, count=0, pointers=0
  - f_ack=t_ack=0, data_2=0, data_2_valid=0
  - buffer_empty=1, buffer_full=0, led=6'b000001
  - Reset mid-operation discards all FIFO contents.
- States: IDLE, COMM_F, WAIT_F, COMM_T, WAIT_T, BUF_EMPTY.
- Transition priority within each state: stop_f_t > full/resume > start.
  - IDLE: start_f -> COMM_F; else start_t -> COMM_T. Simultaneous starts: Fibonacci wins. stop_f_t is ignored.
  - COMM_F: stop_f_t -> BUF_EMPTY; else buffer_full -> WAIT_F. start_t/start_f are ignored.
  - WAIT_F: stop_f_t -> BUF_EMPTY; else count <= LOW_WM -> COMM_F.
  - COMM_T and WAIT_T mirror COMM_F and WAIT_F.
  - BUF_EMPTY: buffer_empty && !data_2_valid -> IDLE. Starts are ignored.
- Push rules:
  - f_ack = (state==COMM_F) && f_valid && !buffer_full; t_ack likewise for COMM_T.
  - f_ack/t_ack are combinational and never both 1.
  - Accepted data is written on the same clk edge.
- Pop rules:
  - A pop occurs when cons_tick && !buffer_empty, in any state except IDLE.
  - data_2/data_2_valid are registered: valid 1 cycle after the tick, data held until the next pop.
  - cons_tick while empty does nothing.
- Occupancy:
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push when full is impossible because ack is gated.
  - Pointers wrap modulo DEPTH.
  - Full/empty flags are registered from next-count, so they are exact on the same edge as the count update.
- Full timing: the edge that makes count=DEPTH also sets buffer_full. The FSM enters WAIT_x on the following edge. No push occurs in between, because ack is gated by full.
- led is a one-hot decode of the state register, registered.

Decomposition:
- Shared package fib_tmr_pkg:
  - state encoding localparams S_IDLE..S_BUF_EMPTY (3-bit)
  - led one-hot map
  - default DATA_W
- One sub-module: sync_fifo (DATA_W, DEPTH). Ports: push, pop, wdata, rdata, count, full, empty; synchronous active-high rst.
- FSM, ack gating and output registers stay in fib_tmr_buf_sched.

Test Plan:
- Reset then start_f pulse, f_valid=1 constant, no cons_tick:
  - 8 acks on consecutive cycles; buffer_full=1 after the 8th.
  - Next cycle led=6'b000100 (WAIT_F); f_ack stays 0.
- From WAIT_F with count=8, 4 cons_ticks:
  - count reaches 4, then state returns to COMM_F (led=6'b000010) on the next edge and f_ack resumes.
- start_f and start_t in the same cycle from IDLE:
  - COMM_F entered; t_ack never asserts while in COMM_F.
- In COMM_T with count=3, stop_f_t pulse, then cons_tick every 5 cycles:
  - BUF_EMPTY (led=6'b100000), 3 data_2_valid pulses with words in push order.
  - IDLE one edge after the last valid pulse drops.
- Simultaneous push+pop at count=5:
  - count stays 5; popped word is the oldest entry; the pushed word appears 5 pops later.
- rst asserted for 1 cycle in WAIT_T with count=8:
  - Next edge: IDLE, buffer_empty=1, data_2_valid=0, outputs match reset values.

Source files
------------

// File: rtl/fib_tmr_pkg.sv
// Shared definitions for the Fibonacci/Timer buffer scheduler.
// Holds the communication-FSM state type, the default data width and the
// state-to-LED one-hot map used for the front-panel indicator.
package fib_tmr_pkg;

  localparam int unsigned DEFAULT_DATA_W = 16;
  localparam int unsigned LED_W          = 6;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COMM_F    = 3'd1,
    S_WAIT_F    = 3'd2,
    S_COMM_T    = 3'd3,
    S_WAIT_T    = 3'd4,
    S_BUF_EMPTY = 3'd5
  } state_t;

  // bit0 IDLE, bit1 COMM_F, bit2 WAIT_F, bit3 COMM_T, bit4 WAIT_T, bit5 BUF_EMPTY
  function automatic logic [LED_W-1:0] led_of(input state_t s);
    logic [LED_W-1:0] v;
    v = '0;
    unique case (s)
      S_IDLE:      v = 6'b000001;
      S_COMM_F:    v = 6'b000010;
      S_WAIT_F:    v = 6'b000100;
      S_COMM_T:    v = 6'b001000;
      S_WAIT_T:    v = 6'b010000;
      S_BUF_EMPTY: v = 6'b100000;
      default:     v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fib_tmr_buf_sched_fifo.sv
// sync_fifo: single-clock FIFO shared by the Fibonacci and Timer producers.
// Ports:
//   clk, rst      clock, synchronous active-high reset (discards contents)
//   push, pop     write / read strobes (caller guarantees no push when full,
//                 no pop when empty)
//   wdata, rdata  write data / head-of-queue data (rdata is combinational)
//   count         occupancy 0..DEPTH
//   full, empty   registered flags, exact on the same edge as count
module sync_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count_d;

  always_comb begin
    count_d = count;
    unique case ({push, pop})
      2'b10:   count_d = count + CNT_ONE;
      2'b01:   count_d = count - CNT_ONE;
      default: count_d = count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_d;
      full  <= (count_d == CNT_FULL);
      empty <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fib_tmr_buf_sched.sv
// fib_tmr_buf_sched: schedules the Fibonacci and Timer producers into one
// shared FIFO and paces the consumer feeding the display path.
// Ports:
//   clk, rst               system clock, synchronous active-high reset
//   start_f, start_t       one-cycle pulses: start/continue a producer
//   stop_f_t               one-cycle pulse: stop production, drain buffer
//   f_valid/f_data/f_ack   Fibonacci producer handshake (ack combinational)
//   t_valid/t_data/t_ack   Timer producer handshake (ack combinational)
//   cons_tick              slow enable; requests one pop
//   data_2, data_2_valid   popped word (held) and one-cycle valid pulse
//   buffer_full/empty      FIFO occupancy flags
//   led                    registered one-hot state indicator
module fib_tmr_buf_sched
  import fib_tmr_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned LOW_WM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_f,
  input  logic              start_t,
  input  logic              stop_f_t,
  input  logic              f_valid,
  input  logic [DATA_W-1:0] f_data,
  output logic              f_ack,
  input  logic              t_valid,
  input  logic [DATA_W-1:0] t_data,
  output logic              t_ack,
  input  logic              cons_tick,
  output logic [DATA_W-1:0] data_2,
  output logic              data_2_valid,
  output logic              buffer_full,
  output logic              buffer_empty,
  output logic [LED_W-1:0]  led
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] RESUME_CNT = CW'(LOW_WM);

  state_t            state;
  state_t            state_d;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic [CW-1:0]     count;

  // Acks are gated by the registered full flag, so a push can never land on
  // a full FIFO during the one cycle before the FSM reaches WAIT_x.
  assign f_ack = (state == S_COMM_F) && f_valid && !buffer_full;
  assign t_ack = (state == S_COMM_T) && t_valid && !buffer_full;
  assign push  = f_ack || t_ack;
  assign wdata = f_ack ? f_data : t_data;
  assign pop   = cons_tick && !buffer_empty && (state != S_IDLE);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (count),
    .full  (buffer_full),
    .empty (buffer_empty)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (start_f)      state_d = S_COMM_F;
        else if (start_t) state_d = S_COMM_T;
      end
      S_COMM_F: begin
        if (stop_f_t)         state_d = S_BUF_EMPTY;
        else if (buffer_full) state_d = S_WAIT_F;
      end
      S_WAIT_F: begin
        if (stop_f_t)                 state_d = S_BUF_EMPTY;
        else if (count <= RESUME_CNT) state_d = S_COMM_F;
      end
      S_COMM_T: begin
        if (stop_f_t)         state_d = S_BUF_EMPTY;
        else if (buffer_full) state_d = S_WAIT_T;
      end
      S_WAIT_T: begin
        if (stop_f_t)                 state_d = S_BUF_EMPTY;
        else if (count <= RESUME_CNT) state_d = S_COMM_T;
      end
      S_BUF_EMPTY: begin
        // Wait for the last popped word to leave data_2 before idling.
        if (buffer_empty && !data_2_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // led is decoded from the next state so it tracks the state register
  // on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      led          <= led_of(S_IDLE);
      data_2       <= '0;
      data_2_valid <= 1'b0;
    end else begin
      state        <= state_d;
      led          <= led_of(state_d);
      data_2_valid <= pop;
      if (pop) data_2 <= rdata;
    end
  end

endmodule
